// File: rtl/sisc_exec_unit_if.sv
// Operand, writeback and status bundle between the SISC execution slice and its
// surroundings (instruction register, register file, status register).
interface sisc_exec_unit_if;
    logic [31:0] ir;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [31:0] mem_data;
    logic        rf_we;
    logic [31:0] wb_data;
    logic        stat_en;
    logic [3:0]  stat;
    logic        halt;
    logic [2:0]  state;

    modport master (
        output ir, rsa, rsb, mem_data,
        input  rf_we, wb_data, stat_en, stat, halt, state
    );

    modport slave (
        input  ir, rsa, rsb, mem_data,
        output rf_we, wb_data, stat_en, stat, halt, state
    );
endinterface

// File: rtl/sisc_exec_unit.sv
// SISC execution slice: multicycle control FSM, 32-bit arithmetic/shift unit with
// {C,V,N,Z} status, and writeback select. Define SISC_EXEC_TRACE_EN for a sim trace.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// START0    | reset landing state
// START1    | second boot cycle
// FETCH     | instruction register being loaded upstream
// DECODE    | ir valid; halt detection, ALU-op validity captured
// EXECUTE   | ALU evaluates rsa/B; stat_en high, flags shown live on stat
// MEM       | memory slot; result and flags already registered
// WRITEBACK | rf_we high for valid ALU ops, wb_data selects result reg
// HALT      | absorbing until reset, halt high
module sisc_exec_unit (
    input  logic             clk,
    input  logic             rst_f,
    sisc_exec_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        START0    = 3'd0,
        START1    = 3'd1,
        FETCH     = 3'd2,
        DECODE    = 3'd3,
        EXECUTE   = 3'd4,
        MEM       = 3'd5,
        WRITEBACK = 3'd6,
        HALT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_ALU_R = 4'b0001;
    localparam logic [3:0] OP_ALU_I = 4'b0010;
    localparam logic [3:0] OP_HLT   = 4'b1111;

    localparam logic [3:0] FN_ADD = 4'b0001;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_OR  = 4'b0011;
    localparam logic [3:0] FN_AND = 4'b0100;
    localparam logic [3:0] FN_NOT = 4'b0101;
    localparam logic [3:0] FN_XOR = 4'b0110;
    localparam logic [3:0] FN_SHL = 4'b0111;
    localparam logic [3:0] FN_SHR = 4'b1000;

    state_t      state_q;
    logic [31:0] result_q;
    logic [3:0]  stat_q;
    logic        rf_we_q;
    logic        stat_en_q;
    logic        halt_q;
    logic        wb_pend_q;

    logic [3:0]  op;
    logic [3:0]  fn;
    logic [15:0] imm;
    logic        alu_valid;
    logic        wb_sel;
    logic        unused_ir_bits;

    assign op  = bus.ir[31:28];
    assign fn  = bus.ir[27:24];
    assign imm = bus.ir[15:0];
    assign unused_ir_bits = ^bus.ir[23:16];

    assign alu_valid = ((op == OP_ALU_R) || (op == OP_ALU_I)) &&
                       (fn >= FN_ADD) && (fn <= FN_SHR);

    // ------------------------------------------------------------------
    // Arithmetic / shift unit
    // ------------------------------------------------------------------
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  sh_amt;
    logic [32:0] add33;
    logic [32:0] sub33;
    logic [32:0] shl33;
    logic [32:0] shr33;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic [3:0]  alu_flags;

    assign alu_a  = bus.rsa;
    assign alu_b  = (op == OP_ALU_I) ? {{16{imm[15]}}, imm} : bus.rsb;
    assign sh_amt = alu_b[4:0];

    // Subtract as A + ~B + 1 so carry out reads as "no borrow".
    assign add33 = {1'b0, alu_a} + {1'b0, alu_b};
    assign sub33 = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    // One guard bit on the outgoing side captures the last bit shifted out.
    assign shl33 = {1'b0, alu_a} << sh_amt;
    assign shr33 = {alu_a, 1'b0} >> sh_amt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (fn)
            FN_ADD: begin
                alu_res = add33[31:0];
                alu_c   = add33[32];
                alu_v   = (alu_a[31] == alu_b[31]) && (add33[31] != alu_a[31]);
            end
            FN_SUB: begin
                alu_res = sub33[31:0];
                alu_c   = sub33[32];
                alu_v   = (alu_a[31] != alu_b[31]) && (sub33[31] != alu_a[31]);
            end
            FN_OR:  alu_res = alu_a | alu_b;
            FN_AND: alu_res = alu_a & alu_b;
            FN_NOT: alu_res = ~alu_a;
            FN_XOR: alu_res = alu_a ^ alu_b;
            FN_SHL: begin
                alu_res = shl33[31:0];
                alu_c   = shl33[32];
            end
            FN_SHR: begin
                alu_res = shr33[32:1];
                alu_c   = shr33[0];
            end
            default: ;
        endcase
        alu_flags = {alu_c, alu_v, alu_res[31], (alu_res == 32'd0)};
    end

    // ------------------------------------------------------------------
    // Control FSM with registered strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q   <= START0;
            result_q  <= '0;
            stat_q    <= '0;
            rf_we_q   <= 1'b0;
            stat_en_q <= 1'b0;
            halt_q    <= 1'b0;
            wb_pend_q <= 1'b0;
        end else begin
            rf_we_q   <= 1'b0;
            stat_en_q <= 1'b0;
            case (state_q)
                START0: state_q <= START1;
                START1: state_q <= FETCH;
                FETCH:  state_q <= DECODE;
                DECODE: begin
                    if (op == OP_HLT) begin
                        state_q <= HALT;
                        halt_q  <= 1'b1;
                    end else begin
                        state_q   <= EXECUTE;
                        stat_en_q <= alu_valid;
                    end
                end
                EXECUTE: begin
                    // stat_en_q doubles as "this EXECUTE carries a valid ALU op".
                    state_q   <= MEM;
                    wb_pend_q <= stat_en_q;
                    if (stat_en_q) begin
                        result_q <= alu_res;
                        stat_q   <= alu_flags;
                    end
                end
                MEM: begin
                    state_q <= WRITEBACK;
                    rf_we_q <= wb_pend_q;
                end
                WRITEBACK: begin
                    state_q   <= FETCH;
                    wb_pend_q <= 1'b0;
                end
                HALT:    state_q <= HALT;
                default: state_q <= START0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs and writeback select
    // ------------------------------------------------------------------
    assign wb_sel       = rf_we_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.stat_en  = stat_en_q;
    assign bus.stat     = stat_en_q ? alu_flags : stat_q;
    assign bus.wb_data  = wb_sel ? result_q : bus.mem_data;
    assign bus.halt     = halt_q;
    assign bus.state    = state_q;

`ifdef SISC_EXEC_TRACE_EN
    always @(posedge clk) begin
        if (rst_f && (state_q == EXECUTE || state_q == WRITEBACK))
            $display("sisc_exec: state=%0d op=%h fn=%h result=%h stat=%b",
                     state_q, op, fn,
                     (state_q == EXECUTE) ? alu_res : result_q, bus.stat);
        if (rst_f && state_q == DECODE && op == OP_HLT)
            $display("sisc_exec: halted");
    end
`endif

endmodule

// File: tb/tb_sisc_exec_unit.sv
// Directed plus randomized bench for sisc_exec_unit with a behavioural ALU/status model.
module tb_sisc_exec_unit;

    logic clk;
    logic rst_f;

    sisc_exec_unit_if bus();

    sisc_exec_unit dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed = 0;
    int          fails  = 0;
    int          total  = 0;
    logic [31:0] res_m;
    logic [3:0]  stat_m;
    logic [31:0] obs_wb;
    logic [3:0]  obs_stat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the arithmetic definitions; flags packed {C,V,N,Z}.
    function automatic void model(input logic [3:0] fn, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic [3:0] f);
        logic [63:0] wide;
        longint      sres;
        int          ia, ib, sh;
        logic        c, v;
        ia = a; ib = b; sh = int'(b[4:0]);
        c = 1'b0; v = 1'b0; r = '0;
        case (fn)
            4'd1: begin
                wide = 64'(a) + 64'(b);
                r    = wide[31:0];
                c    = wide[32];
                sres = longint'(ia) + longint'(ib);
                v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'd2: begin
                r    = a - b;
                c    = (a >= b);
                sres = longint'(ia) - longint'(ib);
                v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'd3: r = a | b;
            4'd4: r = a & b;
            4'd5: r = ~a;
            4'd6: r = a ^ b;
            4'd7: begin
                r = a << sh;
                c = (sh == 0) ? 1'b0 : a[32 - sh];
            end
            4'd8: begin
                r = a >> sh;
                c = (sh == 0) ? 1'b0 : a[sh - 1];
            end
            default: ;
        endcase
        f = {c, v, r[31], (r == 32'd0)};
    endfunction

    // Entered with the DUT sampled in FETCH; leaves it sampled in FETCH (or HALT).
    task automatic exec_instr(input logic [31:0] i, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] m);
        logic [3:0]  op, fn;
        logic [31:0] bop, r;
        logic [3:0]  f;
        logic        valid;
        op = i[31:28];
        fn = i[27:24];
        bus.ir = i; bus.rsa = a; bus.rsb = b; bus.mem_data = m;
        check("fetch_state", 32'(bus.state), 32'd2);
        @(negedge clk);
        check("decode_state", 32'(bus.state), 32'd3);
        check("decode_wb", bus.wb_data, m);
        if (op == 4'hF) begin
            @(negedge clk);
            check("halt_state", 32'(bus.state), 32'd7);
            check("halt_flag", 32'(bus.halt), 32'd1);
            return;
        end
        bop   = (op == 4'd2) ? 32'(int'($signed(i[15:0]))) : b;
        valid = ((op == 4'd1) || (op == 4'd2)) && (fn >= 4'd1) && (fn <= 4'd8);
        model(fn, a, bop, r, f);
        @(negedge clk);
        check("exec_state", 32'(bus.state), 32'd4);
        check("exec_stat_en", 32'(bus.stat_en), 32'(valid));
        check("exec_stat", 32'(bus.stat), 32'(valid ? f : stat_m));
        check("exec_rf_we", 32'(bus.rf_we), 32'd0);
        check("exec_wb", bus.wb_data, m);
        obs_stat = bus.stat;
        if (valid) begin
            res_m  = r;
            stat_m = f;
        end
        @(negedge clk);
        check("mem_state", 32'(bus.state), 32'd5);
        check("mem_stat_en", 32'(bus.stat_en), 32'd0);
        check("mem_stat", 32'(bus.stat), 32'(stat_m));
        check("mem_rf_we", 32'(bus.rf_we), 32'd0);
        @(negedge clk);
        check("wb_state", 32'(bus.state), 32'd6);
        check("wb_rf_we", 32'(bus.rf_we), 32'(valid));
        check("wb_data", bus.wb_data, valid ? res_m : m);
        check("wb_stat", 32'(bus.stat), 32'(stat_m));
        obs_wb = bus.wb_data;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(bus.state), 32'd0);
        check({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
        check({tag, "_stat_en"}, 32'(bus.stat_en), 32'd0);
        check({tag, "_stat"}, 32'(bus.stat), 32'd0);
        check({tag, "_halt"}, 32'(bus.halt), 32'd0);
        check({tag, "_wb"}, bus.wb_data, bus.mem_data);
    endtask

    task automatic boot();
        rst_f = 1'b1;
        @(negedge clk);
        check("boot_start1", 32'(bus.state), 32'd1);
        @(negedge clk);
    endtask

    logic [31:0] specials [6] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                  32'h80000000, 32'h1, 32'h0000001F};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        logic [3:0]  op, fn;
        int          sel;
        rst_f = 1'b0;
        bus.ir = '0; bus.rsa = '0; bus.rsb = '0; bus.mem_data = 32'hA5A5_0001;
        res_m = '0; stat_m = '0; obs_wb = '0; obs_stat = '0;

        // Reset and boot through a NOP
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        boot();
        exec_instr(32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h0BAD_F00D);

        // Register ADD overflow into the sign bit
        exec_instr({4'h1, 4'h1, 24'h0}, 32'h7FFF_FFFF, 32'h1, 32'h0);
        check("add_stat", 32'(obs_stat), 32'b0110);
        check("add_wb", obs_wb, 32'h8000_0000);

        // SUB to zero
        exec_instr({4'h1, 4'h2, 24'h0}, 32'h1234_5678, 32'h1234_5678, 32'h5555_AAAA);
        check("sub_stat", 32'(obs_stat), 32'b1001);
        check("sub_wb", obs_wb, 32'h0);

        // Immediate sign extension: 5 + (-1)
        exec_instr({4'h2, 4'h1, 8'h0, 16'hFFFF}, 32'd5, 32'hDEAD_0000, 32'h0);
        check("imm_stat", 32'(obs_stat), 32'b1000);
        check("imm_wb", obs_wb, 32'd4);

        // Reserved fn leaves memory path selected, then a shift with carry out
        exec_instr({4'h1, 4'hE, 24'h0}, 32'h1, 32'h2, 32'hDEAD_BEEF);
        check("rsvd_wb", obs_wb, 32'hDEAD_BEEF);
        exec_instr({4'h1, 4'h7, 24'h0}, 32'h8000_0001, 32'h1, 32'h0);
        check("shl_wb", obs_wb, 32'h0000_0002);
        check("shl_c", 32'(obs_stat[3]), 32'd1);

        // Randomized instruction mix against the model
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       op = 4'h1;
            else if (sel < 8)  op = 4'h2;
            else if (sel == 8) op = 4'h0;
            else               op = 4'($urandom_range(3, 14));
            fn = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, 8));
            exec_instr({op, fn, 8'($urandom), 16'($urandom)},
                       pick_operand(), pick_operand(), $urandom);
        end

        // Reset in the middle of an instruction: no writeback afterwards
        bus.ir = {4'h1, 4'h1, 24'h0}; bus.rsa = 32'd10; bus.rsb = 32'd20;
        bus.mem_data = 32'h7777_0000;
        repeat (2) @(negedge clk);
        check("midrst_exec", 32'(bus.state), 32'd4);
        rst_f = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        res_m = '0; stat_m = '0;
        boot();
        exec_instr(32'h0000_0000, 32'h0, 32'h0, 32'h1357_9BDF);

        // Halt is absorbing; a single reset edge clears it
        exec_instr({4'hF, 28'h0}, 32'h0, 32'h0, 32'h2468_ACE0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("halt_hold_state", 32'(bus.state), 32'd7);
            check("halt_hold_flag", 32'(bus.halt), 32'd1);
            check("halt_hold_rf_we", 32'(bus.rf_we), 32'd0);
        end
        rst_f = 1'b0;
        @(negedge clk);
        check_reset_outputs("halt_rst");
        stat_m = '0;
        boot();
        exec_instr({4'h2, 4'h6, 8'h0, 16'h00FF}, 32'hF0F0_F0F0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sisc_exec_unit.md
Name: sisc_exec_unit

Overview:
- Execution slice of the SISC processor: multicycle control FSM (ctrl role), 32-bit arithmetic/shift unit with status generation (asu role), and writeback select mux (mux32 role), merged into one block.
- Sits between the instruction register / register file (operands in) and the register file write port / status register (write data, write enable, status out).

Parameters:
- None. Widths are fixed: 32-bit data, 4-bit status, 32-bit instruction.

Ports:
- clk     in   1   system clock, rising edge
- rst_f   in   1   reset, synchronous, active-low
- ir      in   32  instruction: op=ir[31:28], fn=ir[27:24], imm=ir[15:0]
- rsa     in   32  register-file operand A
- rsb     in   32  register-file operand B
- mem_data in  32  alternate writeback source (memory path)
- rf_we   out  1   register-file write enable
- wb_data out  32  writeback data
- stat_en out  1   status register load enable
- stat    out  4   status {C,V,N,Z}
- halt    out  1   processor halted
- state   out  3   current FSM state (debug)

Behaviour:
- Interface: one clock domain (clk); rst_f is synchronous, active-low.
- Reset (rst_f=0 at a rising edge): state=START0; result reg=0; stat=0; rf_we=0; stat_en=0; halt=0.
- FSM encoding: START0=0, START1=1, FETCH=2, DECODE=3, EXECUTE=4, MEM=5, WRITEBACK=6, HALT=7.
- FSM sequence: START0 -> START1 -> FETCH -> DECODE; DECODE -> HALT if op=1111, else EXECUTE; EXECUTE -> MEM -> WRITEBACK -> FETCH.
- HALT is absorbing until reset; halt=1 in HALT.
- Opcodes:
  - 0000 NOP: no writes.
  - 0001 ALU register: B=rsb.
  - 0010 ALU immediate: B=sign-extended imm.
  - 1111 HLT.
  - Others: treated as NOP.
- Operand A is always rsa.
- ALU functions (fn):
  - 0001 ADD A+B
  - 0010 SUB A-B
  - 0011 OR
  - 0100 AND
  - 0101 NOT A
  - 0110 XOR
  - 0111 SHL A by B[4:0]
  - 1000 SHR logical A by B[4:0]
  - Others are reserved.
- Reserved fn acts as NOP: rf_we=0, stat_en=0, result reg unchanged.
- EXECUTE (valid ALU op): result computed combinationally, latched into result reg at the edge leaving EXECUTE.
- stat_en=1 for exactly the EXECUTE cycle; stat presents the new flags combinationally during that cycle.
- stat holds its last value at other times (registered copy).
- Flags:
  - Z = (result==0).
  - N = result[31].
  - ADD: C = carry out of bit 31; V = signed overflow.
  - SUB: computed as A+~B+1; C = carry out (1 = no borrow); V = signed overflow.
  - Logic ops: C=0, V=0.
  - Shifts: C = last bit shifted out (0 if amount=0); V=0.
- Arithmetic wraps modulo 2^32.
- WRITEBACK (valid ALU op): rf_we=1 for exactly one cycle. rf_we=0 in every other state.
- Writeback select: wb_sel=1 during WRITEBACK of ALU ops, else 0.
- wb_data = wb_sel ? result reg : mem_data (combinational).
- ir, rsa, rsb must be stable from DECODE through EXECUTE; rsa/rsb are sampled only in EXECUTE.
- Reset mid-instruction: all outputs return to reset values on that edge; no partial writeback.

Optional Feature:
- Macro: SISC_EXEC_TRACE_EN.
- Defined: synthesizable-excluded simulation block prints state, op, fn, result and stat on every rising edge in EXECUTE and WRITEBACK, plus "halted" once on entering HALT.
- Undefined: no display code; logic identical.

Test Plan:
1. Reset and boot:
   - Stimulus: rst_f=0 for 2 cycles, then 1, ir=NOP.
   - Required: state sequence 0,1,2,3,4,5,6,2; rf_we and stat_en never assert.
2. Register ADD:
   - Stimulus: ir op=0001 fn=0001, rsa=0x7FFFFFFF, rsb=1.
   - Required in EXECUTE: stat_en=1, stat C=0 V=1 N=1 Z=0.
   - Required in WRITEBACK: rf_we=1, wb_data=0x80000000.
3. Register SUB to zero:
   - Stimulus: rsa=rsb=0x12345678, fn=0010.
   - Required: result 0; stat C=1 V=0 N=0 Z=1.
4. Immediate sign-extension:
   - Stimulus: op=0010, fn=0001, rsa=5, imm=0xFFFF.
   - Required: wb_data=4; C=1 Z=0.
5. Reserved function and mux path:
   - Stimulus: op=0001, fn=1110, mem_data=0xDEADBEEF.
   - Required: no rf_we, no stat_en; wb_data=0xDEADBEEF throughout; shift fn=0111 with rsa=0x80000001, rsb=1 gives 0x00000002, C=1.
6. Halt and reset from halt:
   - Stimulus: op=1111.
   - Required: DECODE->HALT, halt=1, state stays 7 for 10+ cycles; rst_f=0 for one edge returns state=0 and halt=0.
